// File: rtl/rv32imf_obi_pkg.sv
// Shared types and constants for the OBI data-bus responder.
package rv32imf_obi_pkg;

  // Read data returned for any access that falls outside the backing array.
  localparam logic [31:0] ERR_RDATA = 32'hBADC_AB1E;

  // Deepest response pipeline the responder supports.
  localparam int unsigned MAX_RESP_LATENCY = 8;

  // One slot of the response pipeline.
  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/rv32imf_resp_delay_line.sv
// Fixed-depth shift register carrying OBI responses; it is also the complete
// outstanding-request tracker because the initiator cannot back-pressure.
module rv32imf_resp_delay_line
  import rv32imf_obi_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  obi_resp_t resp_i,
  output obi_resp_t resp_o
);

  obi_resp_t stage_q [DEPTH];
  obi_resp_t stage_d [DEPTH];

  // Each stage takes the contents of the one before it; stage 0 takes the input.
  always_comb begin
    stage_d[0] = resp_i;
    for (int i = 1; i < int'(DEPTH); i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Advance every cycle; reset discards all in-flight responses at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign resp_o = stage_q[DEPTH-1];

endmodule

// File: rtl/rv32imf_obi_data_responder.sv
// Memory-backed responder for the core data bus: byte-enabled reads/writes to
// an internal word array, in-order responses after a fixed latency, external
// stall for wait-state injection and a saturating out-of-range counter.
module rv32imf_obi_data_responder
  import rv32imf_obi_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = 16384,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned RESP_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic [15:0] err_cnt_o
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // Byte span of the array, kept 33 bits wide so a full 4 GiB span cannot wrap.
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) * 33'd4;

  if (RESP_LATENCY < 1 || RESP_LATENCY > MAX_RESP_LATENCY) begin : g_bad_latency
    $error("RESP_LATENCY must be within 1..MAX_RESP_LATENCY");
  end
  if (DEPTH_WORDS == 0 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("DEPTH_WORDS must be a power of two");
  end
  if ((33'(BASE_ADDR) & (SPAN - 33'd1)) != 33'd0) begin : g_bad_base
    $error("BASE_ADDR must be aligned to DEPTH_WORDS*4");
  end

  logic [31:0]      mem_q [DEPTH_WORDS];
  logic             accept;
  logic             in_range;
  logic [31:0]      off;
  logic [IDX_W-1:0] idx;
  logic [15:0]      err_cnt_q, err_cnt_d;
  obi_resp_t        resp_in, resp_out;

  // Grant is the only combinational path; it is forced low while in reset.
  assign gnt_o = req_i & ~stall_i & rst_ni;

  // Decode the request and build the response that enters the delay line.
  always_comb begin
    accept   = req_i & gnt_o;
    // Wrapped subtraction makes addresses below BASE_ADDR land out of range.
    off      = addr_i - BASE_ADDR;
    in_range = {1'b0, off} < SPAN;
    idx      = off[IDX_W+1:2];
    resp_in       = '0;
    resp_in.valid = accept;
    if (accept && !we_i) begin
      resp_in.rdata = in_range ? mem_q[idx] : ERR_RDATA;
    end
    err_cnt_d = err_cnt_q;
    if (accept && !in_range && err_cnt_q != 16'hFFFF) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // Array write port: only enabled byte lanes change; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (accept && we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Saturating out-of-range counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  rv32imf_resp_delay_line #(
    .DEPTH (RESP_LATENCY)
  ) u_delay (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .resp_i (resp_in),
    .resp_o (resp_out)
  );

  assign rvalid_o  = resp_out.valid;
  assign rdata_o   = resp_out.rdata;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_rv32imf_obi_data_responder.sv
// Bench for rv32imf_obi_data_responder: three instances (latency 1, 4, 8) on a
// 16-word array at 0x1000 share one stimulus; a transaction-history model
// predicts every output each cycle, plus literal spot checks.
module tb_rv32imf_obi_data_responder;

  localparam int HMAX = 80000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;

  logic [2:0]        gnt;
  logic [2:0]        rvalid;
  logic [2:0][31:0]  rdata;
  logic [2:0][15:0]  err;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  rv32imf_obi_data_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h1000), .RESP_LATENCY(1)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .req_i(req), .gnt_o(gnt[0]),
    .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata),
    .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_cnt_o(err[0]));

  rv32imf_obi_data_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h1000), .RESP_LATENCY(4)) u4 (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .req_i(req), .gnt_o(gnt[1]),
    .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata),
    .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_cnt_o(err[1]));

  rv32imf_obi_data_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h1000), .RESP_LATENCY(8)) u8 (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .req_i(req), .gnt_o(gnt[2]),
    .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata),
    .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .err_cnt_o(err[2]));

  // ---------------- behavioural model ----------------
  // hv/hd[e]: did edge e accept a request, and what data it answers with.
  logic        hv [HMAX];
  logic [31:0] hd [HMAX];
  logic [31:0] mmem [16];
  int          edge_n = 0;
  int          flush_edge = 0;
  int unsigned merr = 0;

  function automatic int lat_of(input int i);
    case (i)
      0:       return 1;
      1:       return 4;
      default: return 8;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
  endtask

  // Record each accepted transaction at the edge it happens on.
  initial begin
    forever begin
      @(posedge clk);
      if (edge_n < HMAX - 1) edge_n++;
      hv[edge_n] = 1'b0;
      hd[edge_n] = 32'h0;
      if (rst_n && req && !stall) begin
        logic [31:0] o;
        o = addr - 32'h1000;
        hv[edge_n] = 1'b1;
        if (o < 32'd64) begin
          if (we) begin
            for (int b = 0; b < 4; b++)
              if (be[b]) mmem[o[5:2]][8*b +: 8] = wdata[8*b +: 8];
          end else begin
            hd[edge_n] = mmem[o[5:2]];
          end
        end else begin
          if (!we) hd[edge_n] = 32'hBADC_AB1E;
          if (merr < 65535) merr++;
        end
      end
    end
  end

  // Reset throws away everything accepted so far and clears the error count.
  initial begin
    forever begin
      @(negedge rst_n);
      merr = 0;
      flush_edge = edge_n;
    end
  end

  // Compare all instances against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        int          a;
        logic        ev;
        logic [31:0] ed;
        a  = edge_n - lat_of(i) + 1;
        ev = (a >= 1) && (a > flush_edge) && hv[a];
        ed = ev ? hd[a] : 32'h0;
        chk($sformatf("gnt[L%0d]", lat_of(i)), 32'(gnt[i]), 32'(req & ~stall & rst_n));
        chk($sformatf("rvalid[L%0d]", lat_of(i)), 32'(rvalid[i]), 32'(ev));
        chk($sformatf("rdata[L%0d]", lat_of(i)), rdata[i], ed);
        chk($sformatf("err_cnt[L%0d]", lat_of(i)), 32'(err[i]), merr);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic acc(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    tick();
  endtask

  task automatic idle(input int n);
    req = 1'b0; we = 1'b0; be = 4'h0;
    repeat (n) tick();
  endtask

  initial begin
    int e0;
    int cnt;

    // Reset held with a pending request.
    req = 1'b1; addr = 32'h1000;
    repeat (3) tick();
    chk("reset_gnt", 32'(gnt[0]), 32'h0);
    chk("reset_err", 32'(err[2]), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Give every word a known value.
    for (int w = 0; w < 16; w++) acc(1'b1, 32'h1000 + 32'(4 * w), 32'hA500_0000 | 32'(w), 4'hF);
    idle(9);

    // Byte-enable merge, back to back.
    acc(1'b1, 32'h1010, 32'h1122_3344, 4'hF);
    acc(1'b1, 32'h1010, 32'hAABB_CCDD, 4'b0101);
    acc(1'b0, 32'h1010, 32'h0, 4'h0);
    chk("be_merge_rvalid", 32'(rvalid[0]), 32'h1);
    chk("be_merge_rdata", rdata[0], 32'h11BB_33DD);
    chk("model_be_merge", mmem[4], 32'h11BB_33DD);
    idle(9);

    // Single read latency on every instance.
    acc(1'b0, 32'h1008, 32'h0, 4'h0);
    chk("lat1_pulse", 32'(rvalid[0]), 32'h1);
    chk("lat4_early", 32'(rvalid[1]), 32'h0);
    idle(1);
    chk("lat1_single", 32'(rvalid[0]), 32'h0);
    idle(2);
    chk("lat4_pulse", 32'(rvalid[1]), 32'h1);
    chk("lat4_data", rdata[1], 32'hA500_0002);
    idle(1);
    chk("lat4_single", 32'(rvalid[1]), 32'h0);
    idle(3);
    chk("lat8_pulse", 32'(rvalid[2]), 32'h1);
    chk("lat8_data", rdata[2], 32'hA500_0002);
    idle(3);

    // 16 back-to-back reads.
    for (int w = 0; w < 16; w++) acc(1'b0, 32'h1000 + 32'(4 * w), 32'h0, 4'h0);
    idle(10);

    // Stall pattern 1,0,1,1,0 with the request held.
    e0 = edge_n;
    req = 1'b1; we = 1'b0; addr = 32'h1014;
    stall = 1'b1; tick();
    stall = 1'b0; tick();
    stall = 1'b1; tick();
    tick();
    stall = 1'b0; tick();
    cnt = 0;
    for (int k = 1; k <= 5; k++) if (hv[e0 + k]) cnt++;
    chk("stall_accepts", 32'(cnt), 32'd2);
    idle(10);

    // Out-of-range accesses.
    acc(1'b0, 32'h0FFC, 32'h0, 4'h0);
    chk("oor_rdata", rdata[0], 32'hBADC_AB1E);
    acc(1'b1, 32'h1040, 32'hDEAD_BEEF, 4'hF);
    chk("oor_wr_rdata", rdata[0], 32'h0);
    chk("oor_wr_rvalid", 32'(rvalid[0]), 32'h1);
    acc(1'b0, 32'h103C, 32'h0, 4'h0);
    chk("top_word", rdata[0], 32'hA500_000F);
    chk("oor_err_cnt", 32'(err[0]), 32'd2);
    acc(1'b0, 32'h1000, 32'h0, 4'h0);
    chk("no_wrap_corrupt", rdata[0], 32'hA500_0000);
    idle(9);

    // Drive the error counter into saturation.
    req = 1'b1; we = 1'b0; addr = 32'h2000;
    repeat (65540) tick();
    chk("err_saturated", 32'(err[0]), 32'h0000_FFFF);
    idle(3);
    chk("err_hold", 32'(err[1]), 32'h0000_FFFF);
    idle(6);

    // Reset while three reads are in flight.
    acc(1'b0, 32'h1008, 32'h0, 4'h0);
    acc(1'b0, 32'h100C, 32'h0, 4'h0);
    acc(1'b0, 32'h1010, 32'h0, 4'h0);
    rst_n = 1'b0; req = 1'b0;
    #1;
    chk("rst_flush_rvalid", 32'(rvalid[1]), 32'h0);
    chk("rst_err_clear", 32'(err[0]), 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (rvalid[1]) cnt++;
    end
    chk("no_rvalid_after_rst", 32'(cnt), 32'd0);
    acc(1'b0, 32'h1010, 32'h0, 4'h0);
    idle(3);
    chk("retained_rdata", rdata[1], 32'h11BB_33DD);
    idle(8);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
